// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 4-word register window, small TX FIFO, 8N1 shifter.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module uart_tx_mmio #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [1:0]  a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        tx,
   output logic        irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] A_TXDATA  = 2'd0;
   localparam logic [1:0] A_STATUS  = 2'd1;
   localparam logic [1:0] A_CTRL    = 2'd2;
   localparam logic [1:0] A_SENTCNT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [TW-1:0]    tick, tick_n;
   logic [2:0]       bit_idx, bit_n;
   logic [7:0]       frame_byte, frame_n;
   logic             bit_end;
   logic             frame_done;
   logic             pop;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             full, empty, push;
   logic             enable, overflow;
   logic [31:0]      sentcnt;
   logic [7:0]       last_byte;
   logic             wr_txdata, wr_status, wr_ctrl, wr_sentcnt;
   logic [2:0]       count_rd;
   logic             unused_wd;

   // Bus writes are single-cycle: a write is taken on every edge where we=1,
   // there is no ready/backpressure, and a TXDATA write into a full FIFO is dropped.
   assign wr_txdata  = we && (a == A_TXDATA);
   assign wr_status  = we && (a == A_STATUS);
   assign wr_ctrl    = we && (a == A_CTRL);
   assign wr_sentcnt = we && (a == A_SENTCNT);

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push  = wr_txdata && (!full || pop);

   assign irq      = empty && (state == S_IDLE);
   assign count_rd = 3'(count);
   assign unused_wd = ^wd[31:8];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wd[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         enable    <= 1'b0;
         overflow  <= 1'b0;
         sentcnt   <= '0;
         last_byte <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;
            last_byte <= wd[7:0];
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_ctrl) begin
            enable <= wd[0];
         end
         if (wr_status) begin
            overflow <= 1'b0;
         end else if (wr_txdata && full && !pop) begin
            overflow <= 1'b1;
         end
         // A clear-write beats a same-cycle frame completion.
         if (wr_sentcnt) begin
            sentcnt <= '0;
         end else if (frame_done) begin
            sentcnt <= sentcnt + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tick       <= '0;
         bit_idx    <= '0;
         frame_byte <= '0;
      end else begin
         state      <= state_n;
         tick       <= tick_n;
         bit_idx    <= bit_n;
         frame_byte <= frame_n;
      end
   end

   assign bit_end = (tick == TICK_MAX);

   always_comb begin
      state_n    = state;
      tick_n     = tick;
      bit_n      = bit_idx;
      frame_n    = frame_byte;
      tx         = 1'b1;
      pop        = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable && !empty) begin
               pop     = 1'b1;
               frame_n = mem[rd_ptr];
               tick_n  = '0;
               state_n = S_START;
            end
         end
         S_START: begin
            tx = 1'b0;
            if (bit_end) begin
               tick_n  = '0;
               bit_n   = '0;
               state_n = S_DATA;
            end else begin
               tick_n = tick + 1'b1;
            end
         end
         S_DATA: begin
            tx = frame_byte[bit_idx];
            if (bit_end) begin
               tick_n = '0;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  bit_n = bit_idx + 3'd1;
               end
            end else begin
               tick_n = tick + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            tx = ^frame_byte;
            if (bit_end) begin
               tick_n  = '0;
               state_n = S_STOP;
            end else begin
               tick_n = tick + 1'b1;
            end
         end
`endif
         S_STOP: begin
            tx = 1'b1;
            if (bit_end) begin
               tick_n     = '0;
               frame_done = 1'b1;
               state_n    = S_IDLE;
            end else begin
               tick_n = tick + 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            tick_n  = '0;
         end
      endcase
   end

   always_comb begin
      rd = '0;
      case (a)
         A_TXDATA:  rd = {24'b0, last_byte};
         A_STATUS:  rd = {25'b0, overflow, count_rd, empty, full, (state != S_IDLE)};
         A_CTRL:    rd = {31'b0, enable};
         A_SENTCNT: rd = sentcnt;
         default:   rd = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a line monitor decodes frames from tx and
// compares them with a queue of bytes the bench expects the FIFO to have accepted.
module tb_uart_tx_mmio;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we  = 1'b0;
   logic [1:0]  a   = 2'd0;
   logic [31:0] wd  = '0;
   logic [31:0] rd;
   logic        tx;
   logic        irq;

   uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .we(we), .a(a), .wd(wd), .rd(rd), .tx(tx), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks  = 0;
   int n_pass    = 0;
   int cyc       = 0;
   int model_sent = 0;
   int model_cnt  = 0;
   bit model_ovf  = 1'b0;
   logic [7:0] exp_q[$];
   int start_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] status_word(input bit busy, input int cnt, input bit ovf);
      return {25'b0, ovf, 3'(cnt), (cnt == 0), (cnt == DEPTH), busy};
   endfunction

   // Line monitor: every bit must hold for CPB samples; frames cut by reset are dropped.
   initial begin : monitor
      logic       prev;
      logic [10:0] bits;
      logic [7:0] b8;
      bit         aborted, stable;
      prev = 1'b1;
      bits = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst && prev && !tx) begin
            start_cyc.push_back(cyc);
            aborted = 1'b0;
            stable  = 1'b1;
            for (int b = 0; b < NBITS && !aborted; b++) begin
               for (int k = 0; k < CPB && !aborted; k++) begin
                  if (!(b == 0 && k == 0)) begin
                     @(negedge clk); #1;
                  end
                  if (rst) aborted = 1'b1;
                  else if (k == 0) bits[b] = tx;
                  else if (tx !== bits[b]) stable = 1'b0;
               end
            end
            if (!aborted) begin
               b8 = bits[8:1];
               check("bit_stable", 32'(stable), 32'd1);
               check("stop_bit", 32'(bits[NBITS-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
               check("parity_bit", 32'(bits[9]), 32'(^b8));
`endif
               check("frame_pending", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) check("frame_byte", 32'(b8), 32'(exp_q.pop_front()));
               model_sent++;
            end
         end
         prev = tx;
      end
   end

   task automatic bus_write(input logic [1:0] ad, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; a = ad; wd = d;
      @(negedge clk);
      we = 1'b0;
      if (ad == 2'd3) model_sent = 0;
   endtask

   task automatic bus_read(input logic [1:0] ad, output logic [31:0] d);
      a = ad;
      #1;
      d = rd;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] ad, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(ad, v);
      check(tag, v, exp);
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus_write(2'd0, {24'b0, b});
      if (model_cnt < DEPTH) begin
         exp_q.push_back(b);
         model_cnt++;
      end else begin
         model_ovf = 1'b1;
      end
   endtask

   task automatic wait_drain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         @(negedge clk); #1;
         if (irq && exp_q.size() == 0) done = 1'b1;
      end
      check(tag, 32'(done), 32'd1);
      model_cnt = 0;
   endtask

   task automatic wait_fall(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk); #1;
         if (!tx) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] b;
      int n, edges;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_irq", 32'(irq), 32'd1);
      check_reg("rst_txdata", 2'd0, 32'h0);
      check_reg("rst_status", 2'd1, 32'h4);
      @(negedge clk);
      check_reg("rst_ctrl", 2'd2, 32'h0);
      check_reg("rst_sentcnt", 2'd3, 32'h0);

      // Single frame 0xA5 with exact pop latency
      bus_write(2'd2, 32'd1);
      check_reg("ctrl_on", 2'd2, 32'd1);
      push_byte(8'hA5);
      #1;
      check("tx_before_pop", 32'(tx), 32'd1);
      check_reg("status_one", 2'd1, status_word(0, 1, 0));
      check_reg("txdata_read", 2'd0, 32'hA5);
      @(negedge clk); #1;
      check("tx_fall_latency", 32'(tx), 32'd0);
      wait_drain("drain_a5");
      check_reg("sentcnt_a5", 2'd3, 32'(model_sent));
      check("irq_after_a5", 32'(irq), 32'd1);

      // Overflow with enable off, then back-to-back drain
      bus_write(2'd2, 32'd0);
      bus_write(2'd3, 32'd0);
      for (int i = 1; i <= 5; i++) push_byte(8'(i));
      check_reg("status_overflow", 2'd1, status_word(0, model_cnt, model_ovf));
      start_cyc.delete();
      bus_write(2'd2, 32'd1);
      wait_drain("drain_b2b");
      check("b2b_frames", 32'(start_cyc.size()), 32'd4);
      for (int i = 1; i < start_cyc.size(); i++)
         check("b2b_gap", 32'(start_cyc[i] - start_cyc[i-1]), 32'(NBITS * CPB + 1));
      check_reg("sentcnt_b2b", 2'd3, 32'(model_sent));
      check_reg("status_sticky", 2'd1, status_word(0, 0, model_ovf));
      bus_write(2'd1, 32'd0);
      model_ovf = 1'b0;
      check_reg("ovf_clear", 2'd1, status_word(0, 0, 0));

      // Full FIFO: push lands in the same cycle as the first pop
      bus_write(2'd2, 32'd0);
      for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom_range(0, 255)));
      check_reg("status_full", 2'd1, status_word(0, DEPTH, 0));
      b = 8'($urandom_range(0, 255));
      @(negedge clk);
      we = 1'b1; a = 2'd2; wd = 32'd1;
      @(negedge clk);
      a = 2'd0; wd = {24'b0, b};
      @(negedge clk);
      we = 1'b0;
      exp_q.push_back(b);
      check_reg("full_push_pop", 2'd1, status_word(1, DEPTH, 0));
      wait_drain("drain_full");
      check_reg("sentcnt_full", 2'd3, 32'(model_sent));

      // Reset during DATA bit 3 of 0x3C
      push_byte(8'h3C);
      wait_fall("fall_3c");
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      model_sent = 0; model_cnt = 0; model_ovf = 1'b0;
      #1;
      check("rst_mid_tx", 32'(tx), 32'd1);
      check_reg("rst_mid_status", 2'd1, 32'h4);
      check_reg("rst_mid_sentcnt", 2'd3, 32'h0);
      edges = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (!tx) edges++;
      end
      check("quiet_after_rst", 32'(edges), 32'd0);

      // SENTCNT clear-write on the last STOP cycle
      bus_write(2'd2, 32'd1);
      push_byte(8'h96);
      wait_fall("fall_96");
      repeat (NBITS * CPB - 2) @(negedge clk);
      bus_write(2'd3, 32'd0);
      check_reg("sentcnt_clear_wins", 2'd3, 32'h0);
      wait_drain("drain_96");

      // Randomized rounds, sometimes dropping enable mid-frame
      for (int r = 0; r < 8; r++) begin
         bus_write(2'd2, 32'd0);
         bus_write(2'd3, 32'd0);
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)));
         check_reg("rnd_status", 2'd1, status_word(0, model_cnt, model_ovf));
         bus_write(2'd2, 32'd1);
         if (model_cnt >= 2 && $urandom_range(0, 1) == 1) begin
            wait_fall("rnd_fall");
            bus_write(2'd2, 32'd0);
            model_cnt--;
            repeat (NBITS * CPB + 4) @(negedge clk);
            #1;
            check_reg("rnd_hold_sent", 2'd3, 32'(model_sent));
            check_reg("rnd_hold_status", 2'd1, status_word(0, model_cnt, model_ovf));
            bus_write(2'd2, 32'd1);
         end
         wait_drain("rnd_drain");
         check_reg("rnd_sentcnt", 2'd3, 32'(model_sent));
         bus_write(2'd1, 32'd0);
         model_ovf = 1'b0;
         check_reg("rnd_status_end", 2'd1, status_word(0, 0, 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
